// File: rtl/mnk_game_engine.sv
// N x N board, K-in-a-row game engine: move legality, line-walk win detection, row-major scan-out.
// Optional one-level undo port enabled by defining TTT_UNDO_EN.
module mnk_game_engine #(
    parameter int unsigned N = 3,
    parameter int unsigned K = 3,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
`ifdef TTT_UNDO_EN
    input  logic          undo,
`endif
    input  logic          move_valid,
    output logic          move_ready,
    input  logic [1:0]    move_player,
    input  logic [CW-1:0] move_row,
    input  logic [CW-1:0] move_col,
    output logic          move_ack,
    output logic          move_err,
    output logic [2:0]    err_code,
    output logic [1:0]    win,
    output logic          draw,
    output logic [CW-1:0] scan_row,
    output logic [CW-1:0] scan_col,
    output logic [1:0]    scan_cell,
    output logic          scan_first
);
    localparam int unsigned PW = CW + 1;
    localparam int unsigned NN = N * N;
    localparam int unsigned IW = $clog2(NN);
    localparam int unsigned NW = $clog2(NN + 1);
    localparam int unsigned SW = $clog2(K);
    localparam int unsigned RW = $clog2(K + 1);
    localparam logic [1:0] P_X = 2'b01;
    localparam logic [1:0] P_O = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CHECK} state_t;

    state_t                state;
    logic [1:0]            board [NN];
    logic [1:0]            turn;
    logic [NW-1:0]         count;
    logic [1:0]            req_player;
    logic [CW-1:0]         req_r, req_c;
    logic signed [PW-1:0]  pos_r, pos_c;
    logic [1:0]            dir;
    logic                  sense;
    logic [SW-1:0]         step;
    logic [RW-1:0]         run;
`ifdef TTT_UNDO_EN
    logic [CW-1:0]         last_r, last_c;
    logic                  has_last;
`endif

    function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return IW'(int'(r) * int'(N) + int'(c));
    endfunction

    // Unit step per direction: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.
    function automatic logic signed [PW-1:0] dlt_r(input logic [1:0] d);
        return (d == 2'd0) ? PW'(0) : PW'(1);
    endfunction

    function automatic logic signed [PW-1:0] dlt_c(input logic [1:0] d);
        case (d)
            2'd1:    return PW'(0);
            2'd3:    return PW'(-1);
            default: return PW'(1);
        endcase
    endfunction

    logic signed [PW-1:0] org_r, org_c, step_dr, step_dc;
    logic                 on_board, hit;
    logic [RW-1:0]        run_inc;
    logic [2:0]           wr_err;

    assign org_r = $signed({1'b0, req_r});
    assign org_c = $signed({1'b0, req_c});

`ifdef TTT_UNDO_EN
    assign move_ready = (state == S_IDLE) && !undo;
`else
    assign move_ready = (state == S_IDLE);
`endif

    // Line-walk probe of the cell at (pos_r, pos_c).
    always_comb begin
        step_dr = dlt_r(dir);
        step_dc = dlt_c(dir);
        if (sense) begin
            step_dr = -step_dr;
            step_dc = -step_dc;
        end
        on_board = !pos_r[PW-1] && !pos_c[PW-1]
                   && (int'(pos_r[CW-1:0]) < int'(N)) && (int'(pos_c[CW-1:0]) < int'(N));
        hit      = on_board && (board[cell_idx(pos_r[CW-1:0], pos_c[CW-1:0])] == req_player);
        run_inc  = run + RW'(1);
    end

    // Rejection reason, highest priority first; 0 means legal.
    always_comb begin
        wr_err = 3'd0;
        if ((win != 2'b00) || draw)
            wr_err = 3'd1;
        else if ((req_player == 2'b00) || (req_player == 2'b11)
                 || (int'(req_r) >= int'(N)) || (int'(req_c) >= int'(N)))
            wr_err = 3'd2;
        else if (req_player != turn)
            wr_err = 3'd3;
        else if (board[cell_idx(req_r, req_c)] != 2'b00)
            wr_err = 3'd4;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            for (int i = 0; i < int'(NN); i++) board[i] <= 2'b00;
            turn       <= P_X;
            count      <= '0;
            win        <= 2'b00;
            draw       <= 1'b0;
            move_ack   <= 1'b0;
            move_err   <= 1'b0;
            err_code   <= 3'd0;
            req_player <= 2'b00;
            req_r      <= '0;
            req_c      <= '0;
            pos_r      <= '0;
            pos_c      <= '0;
            dir        <= 2'd0;
            sense      <= 1'b0;
            step       <= '0;
            run        <= '0;
`ifdef TTT_UNDO_EN
            last_r     <= '0;
            last_c     <= '0;
            has_last   <= 1'b0;
`endif
        end else begin
            move_ack <= 1'b0;
            move_err <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef TTT_UNDO_EN
                    if (undo) begin
                        if (has_last) begin
                            board[cell_idx(last_r, last_c)] <= 2'b00;
                            count    <= count - NW'(1);
                            turn     <= (turn == P_X) ? P_O : P_X;
                            win      <= 2'b00;
                            draw     <= 1'b0;
                            has_last <= 1'b0;
                        end else begin
                            move_err <= 1'b1;
                            err_code <= 3'd5;
                        end
                    end else
`endif
                    if (move_valid) begin
                        req_player <= move_player;
                        req_r      <= move_row;
                        req_c      <= move_col;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_err != 3'd0) begin
                        move_err <= 1'b1;
                        err_code <= wr_err;
                        state    <= S_IDLE;
                    end else begin
                        board[cell_idx(req_r, req_c)] <= req_player;
                        count    <= count + NW'(1);
                        turn     <= (turn == P_X) ? P_O : P_X;
                        move_ack <= 1'b1;
                        dir      <= 2'd0;
                        sense    <= 1'b0;
                        step     <= '0;
                        run      <= RW'(1);
                        pos_r    <= org_r;
                        pos_c    <= org_c + PW'(1);
`ifdef TTT_UNDO_EN
                        last_r   <= req_r;
                        last_c   <= req_c;
                        has_last <= 1'b1;
`endif
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (hit && (run_inc >= RW'(K))) begin
                        win   <= req_player;
                        state <= S_IDLE;
                    end else if (hit && (step != SW'(K - 2))) begin
                        run   <= run_inc;
                        step  <= step + SW'(1);
                        pos_r <= pos_r + step_dr;
                        pos_c <= pos_c + step_dc;
                    end else begin
                        // Sense finished: flip to the negative sense, or move to the next direction.
                        if (hit) run <= run_inc;
                        step <= '0;
                        if (!sense) begin
                            sense <= 1'b1;
                            pos_r <= org_r - dlt_r(dir);
                            pos_c <= org_c - dlt_c(dir);
                        end else if (dir == 2'd3) begin
                            draw  <= (count == NW'(NN));
                            state <= S_IDLE;
                        end else begin
                            dir   <= dir + 2'd1;
                            sense <= 1'b0;
                            run   <= RW'(1);
                            pos_r <= org_r + dlt_r(dir + 2'd1);
                            pos_c <= org_c + dlt_c(dir + 2'd1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [CW-1:0] scan_nr, scan_nc;

    always_comb begin
        scan_nr = scan_row;
        scan_nc = scan_col + CW'(1);
        if (scan_col == CW'(N - 1)) begin
            scan_nc = '0;
            scan_nr = (scan_row == CW'(N - 1)) ? '0 : scan_row + CW'(1);
        end
    end

    // Free-running row-major scan of the registered board.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_row   <= '0;
            scan_col   <= '0;
            scan_cell  <= 2'b00;
            scan_first <= 1'b1;
        end else begin
            scan_row   <= scan_nr;
            scan_col   <= scan_nc;
            scan_cell  <= board[cell_idx(scan_nr, scan_nc)];
            scan_first <= (scan_nr == '0) && (scan_nc == '0);
        end
    end
endmodule

// File: tb/tb_mnk_game_engine.sv
// Directed bench for mnk_game_engine: 3x3/K=3 instance (a) and 5x5/K=4 instance (b).
module tb_mnk_game_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_valid, a_ready, a_ack, a_err, a_draw, a_first;
    logic [1:0] a_player, a_row, a_col, a_win, a_cell, a_srow, a_scol;
    logic [2:0] a_code;
    logic       b_valid, b_ready, b_ack, b_err, b_draw, b_first;
    logic [1:0] b_player, b_win, b_cell;
    logic [2:0] b_row, b_col, b_srow, b_scol, b_code;
`ifdef TTT_UNDO_EN
    logic       a_undo, b_undo;
`endif

    int checks = 0;
    int failures = 0;

    mnk_game_engine #(.N(3), .K(3)) dut_a (
        .clk(clk), .reset(reset),
`ifdef TTT_UNDO_EN
        .undo(a_undo),
`endif
        .move_valid(a_valid), .move_ready(a_ready), .move_player(a_player),
        .move_row(a_row), .move_col(a_col), .move_ack(a_ack), .move_err(a_err),
        .err_code(a_code), .win(a_win), .draw(a_draw), .scan_row(a_srow),
        .scan_col(a_scol), .scan_cell(a_cell), .scan_first(a_first)
    );

    mnk_game_engine #(.N(5), .K(4)) dut_b (
        .clk(clk), .reset(reset),
`ifdef TTT_UNDO_EN
        .undo(b_undo),
`endif
        .move_valid(b_valid), .move_ready(b_ready), .move_player(b_player),
        .move_row(b_row), .move_col(b_col), .move_ack(b_ack), .move_err(b_err),
        .err_code(b_code), .win(b_win), .draw(b_draw), .scan_row(b_srow),
        .scan_col(b_scol), .scan_cell(b_cell), .scan_first(b_first)
    );

    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mv(input bit sel, input logic [1:0] p, input int r, input int c,
                      output logic ack, output logic err, output logic [2:0] code);
        int n;
        @(negedge clk);
        n = 0;
        while (!(sel ? b_ready : a_ready) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (sel) begin
            b_valid = 1'b1; b_player = p; b_row = 3'(r); b_col = 3'(c);
        end else begin
            a_valid = 1'b1; a_player = p; a_row = 2'(r); a_col = 2'(c);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk); #1;
        ack  = sel ? b_ack  : a_ack;
        err  = sel ? b_err  : a_err;
        code = sel ? b_code : a_code;
        n = 0;
        while (!(sel ? b_ready : a_ready) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_after_move", 32'(sel ? b_ready : a_ready), 32'd1);
    endtask

    // exp_code 0 means the move must be acknowledged.
    task automatic expect_move(input bit sel, input logic [1:0] p, input int r, input int c,
                               input logic [2:0] exp_code, input string tag);
        logic ack, err;
        logic [2:0] code;
        mv(sel, p, r, c, ack, err, code);
        check({tag, "_ack"}, 32'(ack), 32'(exp_code == 3'd0));
        check({tag, "_err"}, 32'(err), 32'(exp_code != 3'd0));
        if (exp_code != 3'd0) check({tag, "_code"}, 32'(code), 32'(exp_code));
    endtask

    task automatic scan_at(input int r, input int c, output logic [1:0] v);
        int n;
        bit found;
        found = 1'b0;
        v = 2'bxx;
        for (n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (int'(a_srow) == r && int'(a_scol) == c) begin
                found = 1'b1;
                v = a_cell;
            end
        end
        check("scan_found", 32'(found), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] v;
        logic [1:0] exp_draw [9];
        int n;
        exp_draw = '{X, O, X, X, O, O, O, X, X};

        reset = 1'b0;
        a_valid = 1'b0; a_player = 2'b00; a_row = '0; a_col = '0;
        b_valid = 1'b0; b_player = 2'b00; b_row = '0; b_col = '0;
`ifdef TTT_UNDO_EN
        a_undo = 1'b0; b_undo = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_win", 32'(a_win), 32'd0);
        check("rst_draw", 32'(a_draw), 32'd0);
        check("rst_ack", 32'(a_ack), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_code", 32'(a_code), 32'd0);
        check("rst_srow", 32'(a_srow), 32'd0);
        check("rst_scol", 32'(a_scol), 32'd0);
        check("rst_first", 32'(a_first), 32'd1);
        check("rst_cell", 32'(a_cell), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // Top-row win for X
        expect_move(0, X, 0, 0, 3'd0, "g1_m1");
        expect_move(0, O, 1, 0, 3'd0, "g1_m2");
        expect_move(0, X, 0, 1, 3'd0, "g1_m3");
        expect_move(0, O, 1, 1, 3'd0, "g1_m4");
        check("g1_nowin", 32'(a_win), 32'd0);
        expect_move(0, X, 0, 2, 3'd0, "g1_m5");
        check("g1_win", 32'(a_win), 32'd1);
        check("g1_nodraw", 32'(a_draw), 32'd0);
        expect_move(0, O, 2, 2, 3'd1, "g1_over");
        expect_move(0, 2'b11, 0, 0, 3'd1, "g1_over_parse");
        scan_at(2, 2, v);
        check("g1_cell22_empty", 32'(v), 32'd0);
        scan_at(0, 1, v);
        check("g1_cell01_x", 32'(v), 32'(X));
        check("g1_win_sticky", 32'(a_win), 32'd1);

        // Turn, occupancy and parse errors
        do_reset();
        check("g2_win_clr", 32'(a_win), 32'd0);
        expect_move(0, X, 1, 1, 3'd0, "g2_m1");
        expect_move(0, X, 0, 0, 3'd3, "g2_turn");
        expect_move(0, O, 1, 1, 3'd4, "g2_occ");
        expect_move(0, 2'b11, 0, 0, 3'd2, "g2_p11");
        expect_move(0, O, 3, 0, 3'd2, "g2_row3");
        expect_move(0, O, 0, 0, 3'd0, "g2_m2");
        check("g2_code_held", 32'(a_code), 32'd2);

        // Reset while CHECK is walking
        do_reset();
        @(negedge clk);
        a_valid = 1'b1; a_player = X; a_row = 2'd0; a_col = 2'd0;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        check("rc_ack", 32'(a_ack), 32'd1);
        check("rc_busy", 32'(a_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rc_ready", 32'(a_ready), 32'd1);
        check("rc_ack_clr", 32'(a_ack), 32'd0);
        check("rc_first", 32'(a_first), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        scan_at(0, 0, v);
        check("rc_cell_clr", 32'(v), 32'd0);
        expect_move(0, X, 2, 2, 3'd0, "rc_turn_x");

        // Full board without a line
        do_reset();
        expect_move(0, X, 0, 0, 3'd0, "d_m1");
        expect_move(0, O, 0, 1, 3'd0, "d_m2");
        expect_move(0, X, 0, 2, 3'd0, "d_m3");
        expect_move(0, O, 1, 1, 3'd0, "d_m4");
        expect_move(0, X, 1, 0, 3'd0, "d_m5");
        expect_move(0, O, 1, 2, 3'd0, "d_m6");
        expect_move(0, X, 2, 1, 3'd0, "d_m7");
        expect_move(0, O, 2, 0, 3'd0, "d_m8");
        check("d_nodraw8", 32'(a_draw), 32'd0);
        expect_move(0, X, 2, 2, 3'd0, "d_m9");
        check("d_draw", 32'(a_draw), 32'd1);
        check("d_win", 32'(a_win), 32'd0);
        n = 0;
        @(negedge clk);
        while (!a_first && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("d_first_found", 32'(a_first), 32'd1);
        for (int i = 0; i < 18; i++) begin
            check("d_srow", 32'(a_srow), 32'((i % 9) / 3));
            check("d_scol", 32'(a_scol), 32'(i % 3));
            check("d_cell", 32'(a_cell), 32'(exp_draw[i % 9]));
            check("d_first", 32'(a_first), 32'((i % 9) == 0));
            @(negedge clk);
        end
        expect_move(0, O, 0, 0, 3'd1, "d_over");

        // 5x5 K=4: a row-major run across the row edge is not a line
        do_reset();
        expect_move(1, X, 0, 2, 3'd0, "w_m1");
        expect_move(1, O, 4, 4, 3'd0, "w_m2");
        expect_move(1, X, 0, 3, 3'd0, "w_m3");
        expect_move(1, O, 4, 3, 3'd0, "w_m4");
        expect_move(1, X, 0, 4, 3'd0, "w_m5");
        expect_move(1, O, 4, 1, 3'd0, "w_m6");
        expect_move(1, X, 1, 0, 3'd0, "w_m7");
        check("w_nowrap", 32'(b_win), 32'd0);
        expect_move(1, O, 5, 0, 3'd2, "w_row5");

        // 5x5 K=4 anti-diagonal win
        do_reset();
        expect_move(1, X, 0, 3, 3'd0, "ad_m1");
        expect_move(1, O, 4, 4, 3'd0, "ad_m2");
        expect_move(1, X, 1, 2, 3'd0, "ad_m3");
        expect_move(1, O, 4, 3, 3'd0, "ad_m4");
        expect_move(1, X, 2, 1, 3'd0, "ad_m5");
        expect_move(1, O, 4, 1, 3'd0, "ad_m6");
        check("ad_nowin", 32'(b_win), 32'd0);
        expect_move(1, X, 3, 0, 3'd0, "ad_m7");
        check("ad_win", 32'(b_win), 32'd1);

`ifdef TTT_UNDO_EN
        do_reset();
        expect_move(0, X, 0, 0, 3'd0, "u_m1");
        @(negedge clk);
        a_undo = 1'b1;
        @(posedge clk); #1;
        a_undo = 1'b0;
        check("u1_err", 32'(a_err), 32'd0);
        scan_at(0, 0, v);
        check("u1_cell", 32'(v), 32'd0);
        @(negedge clk);
        a_undo = 1'b1;
        @(posedge clk); #1;
        a_undo = 1'b0;
        check("u2_err", 32'(a_err), 32'd1);
        check("u2_code", 32'(a_code), 32'd5);
        expect_move(0, X, 1, 1, 3'd0, "u_turn_x");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
